// File: rtl/demod_audio_out.sv
// Audio back-end: AM/FM/PM source select, AM carrier-DC removal, block-average
// decimation, offset-binary DAC formatting and a small output FIFO.
module demod_audio_out #(
  parameter int IN_WIDTH   = 12,
  parameter int OUT_WIDTH  = 10,
  parameter int DECIM_LOG2 = 3,
  parameter int DC_SHIFT   = 8,
  parameter int FIFO_LOG2  = 2
) (
  input  logic                 clk_in,
  input  logic                 RST,
  input  logic [1:0]           sel,
  input  logic [IN_WIDTH-1:0]  am_in,
  input  logic [IN_WIDTH-1:0]  fm_in,
  input  logic [IN_WIDTH-1:0]  pm_in,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic [FIFO_LOG2:0]   fifo_level
);

  localparam int IW     = IN_WIDTH;
  localparam int OW     = OUT_WIDTH;
  localparam int YW     = IW + 1;
  localparam int DW     = IW + DC_SHIFT;
  localparam int AW     = IW + 1 + DECIM_LOG2;
  localparam int STAGES = 3;
  localparam int DEPTH  = 1 << FIFO_LOG2;

  localparam logic signed [AW-1:0] S_MAX = AW'((1 << (OW-1)) - 1);
  localparam logic signed [AW-1:0] S_MIN = AW'(-(1 << (OW-1)));
  localparam logic [OW-1:0]        MID   = {1'b1, {(OW-1){1'b0}}};
  localparam logic [FIFO_LOG2:0]   FULL  = (FIFO_LOG2+1)'(DEPTH);

  // vld_pipe[0]: input regs, [1]: mux, [2]: DC removal, [3]: block average ready
  logic [STAGES:0] vld_pipe;

  // stage 0: input capture
  logic [1:0]           sel_in;
  logic signed [IW-1:0] am_r, fm_r, pm_r;

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      sel_in <= '0;
      am_r   <= '0;
      fm_r   <= '0;
      pm_r   <= '0;
    end else if (in_valid) begin
      sel_in <= sel;
      am_r   <= am_in;
      fm_r   <= fm_in;
      pm_r   <= pm_in;
    end
  end

  // stage 1: source mux and restart detect
  logic signed [IW-1:0] x;
  logic [1:0]           sel_r;
  logic                 restart1, is_am1;

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      x        <= '0;
      sel_r    <= '0;
      restart1 <= 1'b0;
      is_am1   <= 1'b0;
    end else if (vld_pipe[0]) begin
      case (sel_in)
        2'b00:   x <= am_r;
        2'b01:   x <= fm_r;
        2'b10:   x <= pm_r;
        default: x <= '0;
      endcase
      sel_r    <= sel_in;
      restart1 <= (sel_in != sel_r);
      is_am1   <= (sel_in == 2'b00);
    end
  end

  // stage 2: DC tracker; a restart sample sees a cleared tracker
  logic signed [DW-1:0] dc, dc_b;
  logic signed [IW-1:0] dc_q;
  logic signed [YW-1:0] y_am, y;
  logic                 restart2;

  always_comb begin
    dc_b = restart1 ? '0 : dc;
    dc_q = dc_b[DW-1:DC_SHIFT];
    y_am = {x[IW-1], x} - {dc_q[IW-1], dc_q};
  end

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      dc       <= '0;
      y        <= '0;
      restart2 <= 1'b0;
    end else if (vld_pipe[1]) begin
      restart2 <= restart1;
      if (is_am1) begin
        y  <= y_am;
        dc <= dc_b + DW'(y_am);
      end else begin
        y  <= {x[IW-1], x};
        dc <= dc_b;
      end
    end
  end

  // stage 3: block accumulate
  logic signed [AW-1:0]   acc, acc_b, sum, avg;
  logic [DECIM_LOG2-1:0]  cnt, cnt_b;
  logic                   blk_end;

  always_comb begin
    acc_b   = restart2 ? '0 : acc;
    cnt_b   = restart2 ? '0 : cnt;
    sum     = acc_b + AW'(y);
    blk_end = (cnt_b == '1);
  end

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      acc <= '0;
      cnt <= '0;
      avg <= '0;
    end else if (vld_pipe[2]) begin
      if (blk_end) begin
        avg <= sum >>> DECIM_LOG2;
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt_b + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!RST) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= in_valid;
      vld_pipe[1] <= vld_pipe[0];
      vld_pipe[2] <= vld_pipe[1];
      vld_pipe[3] <= vld_pipe[2] && blk_end;
    end
  end

  // stage 4: rescale, clamp, offset binary
  logic signed [AW-1:0] s_full;
  logic [OW-1:0]        s_sat, word;

  always_comb begin
    s_full = avg >>> (IW - OW);
    if (s_full > S_MAX)      s_sat = {1'b0, {(OW-1){1'b1}}};
    else if (s_full < S_MIN) s_sat = {1'b1, {(OW-1){1'b0}}};
    else                     s_sat = s_full[OW-1:0];
    word = {~s_sat[OW-1], s_sat[OW-2:0]};
  end

  // output FIFO; a full FIFO still accepts a word when it pops the same cycle
  logic [OW-1:0]        mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic                 push, pop, do_push, full;

  always_comb begin
    full    = (fifo_level == FULL);
    push    = vld_pipe[3];
    pop     = out_valid && out_ready;
    do_push = push && (!full || pop);
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  assign out_valid = (fifo_level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : MID;

endmodule

// File: tb/tb_demod_audio_out.sv
// Scoreboard bench for demod_audio_out: directed sample streams, expected
// DAC words queued at issue time and checked by a forked output monitor.
module tb_demod_audio_out;
  localparam int IW = 12;
  localparam int OW = 10;

  logic          clk_in = 1'b0;
  logic          RST = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [IW-1:0] am_in = '0, fm_in = '0, pm_in = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_valid, overflow;
  logic [2:0]    fifo_level;

  always #5 clk_in = ~clk_in;

  demod_audio_out dut (
    .clk_in(clk_in), .RST(RST), .sel(sel),
    .am_in(am_in), .fm_in(fm_in), .pm_in(pm_in), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  typedef struct { int val; int tol; bit chk; } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_word(input int v, input int tol, input bit chk);
    exp_t e;
    e.val = v; e.tol = tol; e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    int d;
    forever begin
      @(negedge clk_in);
      if (RST && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0d expected none", out_data);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            checks++;
            d = int'(out_data) - e.val;
            if (d < 0) d = -d;
            if (d > e.tol) begin
              errors++;
              $display("FAIL word: got %0d expected %0d (+-%0d)", out_data, e.val, e.tol);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] s, input int a, input int f, input int p);
    sel = s; am_in = a[IW-1:0]; fm_in = f[IW-1:0]; pm_in = p[IW-1:0];
    in_valid = 1'b1;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (3) begin
      sel = 2'($urandom()); am_in = IW'($urandom()); fm_in = IW'($urandom());
      pm_in = IW'($urandom()); in_valid = 1'($urandom());
      @(posedge clk_in); #1;
    end
    in_valid = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < max) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
    end
  endtask

  initial begin
    fork monitor(); join_none

    // reset state
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 512);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    RST = 1'b1;
    out_ready = 1'b1;

    // FM full-scale negative, with latency
    for (int i = 0; i < 8; i++) send(2'b01, 0, -2048, 0);
    expect_word(0, 0, 1);
    repeat (3) @(posedge clk_in);
    #1 check("lat_k3_valid", out_valid, 0);
    @(posedge clk_in); #1;
    check("lat_k4_valid", out_valid, 1);
    check("lat_k4_level", fifo_level, 1);
    drain("fm_neg", 50);
    check("idle_midscale", out_data, 512);

    // FM full-scale positive
    for (int i = 0; i < 8; i++) send(2'b01, 0, 2047, 0);
    expect_word(1023, 0, 1);
    drain("fm_pos", 50);

    // mode switch mid-block discards FM partial
    for (int i = 0; i < 3; i++) send(2'b01, 0, 2047, 0);
    for (int i = 0; i < 8; i++) send(2'b10, 0, 0, -1024);
    expect_word(256, 0, 1);
    drain("switch", 50);

    // AM DC removal: first word 610, settled words at midscale
    do_reset(); RST = 1'b1;
    for (int i = 0; i < 8224; i++) begin
      send(2'b00, 400, 0, 0);
      if (i % 8 == 7) begin
        if (i == 7)         expect_word(610, 0, 1);
        else if (i >= 8192) expect_word(512, 1, 1);
        else                expect_word(0, 0, 0);
      end
    end
    drain("am_dc", 100);

    // AM saturation on a large positive step
    do_reset(); RST = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      send(2'b00, -2048, 0, 0);
      if (i % 8 == 7) expect_word(0, 0, 0);
    end
    for (int i = 0; i < 8; i++) send(2'b00, 2047, 0, 0);
    expect_word(1023, 0, 1);
    drain("am_sat", 100);

    // overflow and backpressure
    do_reset(); RST = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) send(2'b01, 0, 1024, 0);
    for (int i = 0; i < 4; i++) expect_word(768, 0, 1);
    repeat (5) @(posedge clk_in);
    #1;
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", out_valid, 1);
    check("ovf_head", out_data, 768);
    out_ready = 1'b1;
    drain("ovf", 50);
    check("ovf_drained_valid", out_valid, 0);
    check("ovf_drained_level", fifo_level, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_midscale", out_data, 512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
